// File: rtl/tros_meas_sequencer.sv
// Measurement sequencer for the ring-oscillator frequency counters: clear, gate, settle, latch,
// then serialize {1010, select, count} MSB first, over one sweep or continuously.
module tros_meas_sequencer #(
   parameter int LENGTH      = 20,
   parameter int NUM_RO      = 3,
   parameter int GATE_LOG2   = 10,
   parameter int RST_CYCLES  = 2,
   parameter int SYNC_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              continuous,
   input  logic [NUM_RO-1:0] ro_mask,
   input  logic [1:0]        gate_len_sel,
   input  logic [LENGTH-1:0] cycle_count,
   output logic              ctr_reset,
   output logic              gate,
   output logic              latch_counter,
   output logic [1:0]        counter_select,
   output logic              ser_data,
   output logic              ser_valid,
   output logic              frame_done,
   output logic              busy
);

   localparam int FRAME_W = LENGTH + 6;
   localparam int CW      = GATE_LOG2 + 7;

   typedef enum logic [2:0] {
      IDLE, CLEAR, GATE, SETTLE, LATCH, CAPTURE, SHIFT, NEXT
   } state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      gate_last;
   logic [NUM_RO-1:0]  mask_q;
   logic [1:0]         gsel_q;
   logic [FRAME_W-1:0] shift_reg;
   logic [2:0]         first_pick;
   logic [2:0]         next_pick;

   // Returns {found, index}: lowest set bit, or lowest set bit above cur when from_start=0.
   function automatic logic [2:0] pick(input logic [NUM_RO-1:0] m, input logic [1:0] cur,
                                       input logic from_start);
      logic [2:0] r;
      r = '0;
      for (int i = NUM_RO - 1; i >= 0; i--)
         if (m[i] && (from_start || i > int'(cur))) r = {1'b1, 2'(i)};
      return r;
   endfunction

   always_comb begin
      gate_last  = (CW'(1) << (GATE_LOG2 + 2 * int'(gsel_q))) - CW'(1);
      first_pick = pick(ro_mask, 2'd0, 1'b1);
      next_pick  = pick(mask_q, counter_select, 1'b0);
   end

   assign busy     = (state != IDLE);
   assign ser_data = ser_valid & shift_reg[FRAME_W-1];

   // NOTE: every state register below uses non-blocking assignment so all of them update
   // together from the pre-edge values; blocking here would create ordering-dependent logic.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         mask_q         <= '0;
         gsel_q         <= '0;
         shift_reg      <= '0;
         ctr_reset      <= 1'b0;
         gate           <= 1'b0;
         latch_counter  <= 1'b0;
         counter_select <= '0;
         ser_valid      <= 1'b0;
         frame_done     <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && first_pick[2]) begin
                  mask_q         <= ro_mask;
                  gsel_q         <= gate_len_sel;
                  counter_select <= first_pick[1:0];
                  cnt            <= '0;
                  state          <= CLEAR;
               end
            end
            CLEAR: begin
               if (cnt == CW'(RST_CYCLES)) begin
                  ctr_reset <= 1'b0;
                  gate      <= 1'b1;
                  cnt       <= '0;
                  state     <= GATE;
               end else begin
                  ctr_reset <= 1'b1;
                  cnt       <= cnt + CW'(1);
               end
            end
            GATE: begin
               if (cnt == gate_last) begin
                  gate  <= 1'b0;
                  cnt   <= '0;
                  state <= SETTLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            SETTLE: begin
               if (cnt == CW'(SYNC_CYCLES - 1)) begin
                  latch_counter <= 1'b1;
                  cnt           <= '0;
                  state         <= LATCH;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            LATCH: begin
               if (cnt == CW'(SYNC_CYCLES - 1)) begin
                  latch_counter <= 1'b0;
                  cnt           <= '0;
                  state         <= CAPTURE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            CAPTURE: begin
               shift_reg <= {4'b1010, counter_select, cycle_count};
               ser_valid <= 1'b1;
               cnt       <= '0;
               state     <= SHIFT;
            end
            SHIFT: begin
               shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
               if (cnt == CW'(FRAME_W - 1)) begin
                  ser_valid  <= 1'b0;
                  frame_done <= 1'b1;
                  state      <= NEXT;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            NEXT: begin
               cnt <= '0;
               if (next_pick[2]) begin
                  counter_select <= next_pick[1:0];
                  state          <= CLEAR;
               end else if (continuous && first_pick[2]) begin
                  mask_q         <= ro_mask;
                  gsel_q         <= gate_len_sel;
                  counter_select <= first_pick[1:0];
                  state          <= CLEAR;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tros_meas_sequencer.sv
// Directed bench for tros_meas_sequencer: per-RO strobe timing, frame contents, sweep control,
// reset recovery and output invariants, all against hand-computed expectations.
module tb_tros_meas_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        continuous;
   logic [2:0]  ro_mask;
   logic [1:0]  gate_len_sel;
   logic [19:0] cycle_count;
   logic        ctr_reset, gate, latch_counter;
   logic [1:0]  counter_select;
   logic        ser_data, ser_valid, frame_done, busy;

   int checks = 0;
   int errors = 0;
   int excl_viol = 0;
   int sel_viol = 0;
   int data_viol = 0;

   logic [1:0] prev_sel;
   logic       prev_fd;
   logic       prev_busy;

   typedef struct {
      int          wait_n;
      int          rst_len;
      int          gate_len;
      int          settle_len;
      int          latch_len;
      int          cap_len;
      int          nbits;
      logic [63:0] frame;
      logic [1:0]  sel;
      logic        fd;
   } meas_t;

   always #5 clk = ~clk;

   tros_meas_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .continuous(continuous), .ro_mask(ro_mask),
      .gate_len_sel(gate_len_sel), .cycle_count(cycle_count), .ctr_reset(ctr_reset), .gate(gate),
      .latch_counter(latch_counter), .counter_select(counter_select), .ser_data(ser_data),
      .ser_valid(ser_valid), .frame_done(frame_done), .busy(busy)
   );

   // Continuous invariants: strobes one-hot-or-zero, quiet ser_data, select moves only out of NEXT.
   always @(negedge clk) begin
      if (int'(ctr_reset) + int'(gate) + int'(latch_counter) > 1) excl_viol <= excl_viol + 1;
      if (!ser_valid && ser_data) data_viol <= data_viol + 1;
      if (!reset && prev_busy && !prev_fd && counter_select !== prev_sel) sel_viol <= sel_viol + 1;
      prev_sel  <= counter_select;
      prev_fd   <= frame_done;
      prev_busy <= busy;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic sig(input int which);
      case (which)
         0:       return ctr_reset;
         1:       return gate;
         2:       return latch_counter;
         3:       return ser_valid;
         default: return busy;
      endcase
   endfunction

   task automatic run_len(input int which, input logic level, input int bound, output int n);
      n = 0;
      while (sig(which) === level && n < bound) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Follows one RO from the first ctr_reset cycle to the frame_done cycle (samples on negedge).
   task automatic measure(output meas_t m);
      m.wait_n = 0;
      m.nbits  = 0;
      m.frame  = '0;
      while (ctr_reset !== 1'b1 && m.wait_n < 200) begin
         @(negedge clk);
         m.wait_n++;
      end
      m.sel = counter_select;
      run_len(0, 1'b1, 100, m.rst_len);
      run_len(1, 1'b1, 70000, m.gate_len);
      run_len(2, 1'b0, 100, m.settle_len);
      run_len(2, 1'b1, 100, m.latch_len);
      run_len(3, 1'b0, 100, m.cap_len);
      while (ser_valid === 1'b1 && m.nbits < 100) begin
         m.frame = {m.frame[62:0], ser_data};
         m.nbits++;
         @(negedge clk);
      end
      m.fd = frame_done;
   endtask

   function automatic logic [191:0] timing_of(input meas_t m);
      return {32'(m.rst_len), 32'(m.gate_len), 32'(m.settle_len), 32'(m.latch_len),
              32'(m.cap_len), 32'(m.nbits)};
   endfunction

   function automatic logic [191:0] exp_timing(input int w);
      return {32'd2, 32'(w), 32'd4, 32'd4, 32'd1, 32'd26};
   endfunction

   function automatic logic [28:0] frame_of(input meas_t m);
      return {m.sel, m.frame[25:0], m.fd};
   endfunction

   function automatic logic [28:0] exp_frame(input logic [1:0] s);
      return {s, 4'b1010, s, 20'h12345, 1'b1};
   endfunction

   function automatic logic [7:0] outputs_now();
      return {ctr_reset, gate, latch_counter, counter_select, ser_data, ser_valid, frame_done} |
             {7'd0, busy};
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (outputs_now() !== 8'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b busy=%b, expected all zero", outputs_now(), busy);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      meas_t m;
      ro_mask = 3'b101;
      gate_len_sel = 2'd0;
      continuous = 1'b0;
      pulse_start();
      measure(m);
      checks++;
      if (m.wait_n + m.rst_len !== 3) begin
         errors++;
         $display("FAIL basic_gate_rise: gate rose %0d cycles after start, expected 3",
                  m.wait_n + m.rst_len);
      end
      checks++;
      if (timing_of(m) !== exp_timing(1024)) begin
         errors++;
         $display("FAIL basic_timing_ro0: got %h, expected %h", timing_of(m), exp_timing(1024));
      end
      checks++;
      if (frame_of(m) !== exp_frame(2'd0)) begin
         errors++;
         $display("FAIL basic_frame_ro0: got %h, expected %h", frame_of(m), exp_frame(2'd0));
      end
      measure(m);
      checks++;
      if (timing_of(m) !== exp_timing(1024)) begin
         errors++;
         $display("FAIL basic_timing_ro2: got %h, expected %h", timing_of(m), exp_timing(1024));
      end
      checks++;
      if (frame_of(m) !== exp_frame(2'd2)) begin
         errors++;
         $display("FAIL basic_frame_ro2: got %h, expected %h", frame_of(m), exp_frame(2'd2));
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_drop: busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_gate_len();
      meas_t m;
      logic [1:0] sels [2];
      int widths [2];
      sels[0] = 2'd1; widths[0] = 4096;
      sels[1] = 2'd3; widths[1] = 65536;
      ro_mask = 3'b001;
      continuous = 1'b0;
      for (int k = 0; k < 2; k++) begin
         gate_len_sel = sels[k];
         pulse_start();
         measure(m);
         checks++;
         if (timing_of(m) !== exp_timing(widths[k])) begin
            errors++;
            $display("FAIL gate_len_sel%0d: got %h, expected %h", sels[k], timing_of(m),
                     exp_timing(widths[k]));
         end
         checks++;
         if (frame_of(m) !== exp_frame(2'd0)) begin
            errors++;
            $display("FAIL gate_len_frame%0d: got %h, expected %h", sels[k], frame_of(m),
                     exp_frame(2'd0));
         end
         @(negedge clk);
      end
      gate_len_sel = 2'd0;
   endtask

   task automatic test_empty_mask();
      logic seen;
      seen = 1'b0;
      ro_mask = 3'b000;
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         seen = seen | busy | ctr_reset | gate | latch_counter | ser_valid | frame_done;
         @(negedge clk);
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL empty_mask: activity=%b, expected 0", seen);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      ro_mask = 3'b101;
      gate_len_sel = 2'd0;
      pulse_start();
      n = 0;
      while (gate !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      checks++;
      if (gate !== 1'b1) begin
         errors++;
         $display("FAIL reset_gate_reach: gate=%b, expected 1", gate);
      end
      #2 reset = 1'b1;
      @(negedge clk);
      checks++;
      if (outputs_now() !== 8'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_gate: got %b busy=%b, expected all zero", outputs_now(), busy);
      end
      reset = 1'b0;
      pulse_start();
      n = 0;
      while (ser_valid !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (ser_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_shift_reach: ser_valid=%b, expected 1", ser_valid);
      end
      #2 reset = 1'b1;
      @(negedge clk);
      checks++;
      if (outputs_now() !== 8'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_shift: got %b busy=%b, expected all zero", outputs_now(), busy);
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_stays_idle: busy=%b, expected 0", busy);
      end
      test_basic();
   endtask

   task automatic test_continuous();
      meas_t m;
      logic seen;
      logic [1:0] exp_sel [3];
      exp_sel[0] = 2'd0; exp_sel[1] = 2'd1; exp_sel[2] = 2'd0;
      continuous = 1'b1;
      ro_mask = 3'b011;
      gate_len_sel = 2'd0;
      pulse_start();
      for (int k = 0; k < 2; k++) begin
         measure(m);
         checks++;
         if (frame_of(m) !== exp_frame(exp_sel[k])) begin
            errors++;
            $display("FAIL cont_frame%0d: got %h, expected %h", k, frame_of(m),
                     exp_frame(exp_sel[k]));
         end
      end
      fork
         measure(m);
         begin
            repeat (100) @(negedge clk);
            continuous = 1'b0;
            ro_mask = 3'b001;
            gate_len_sel = 2'd2;
         end
      join
      checks++;
      if (frame_of(m) !== exp_frame(exp_sel[2])) begin
         errors++;
         $display("FAIL cont_frame2: got %h, expected %h", frame_of(m), exp_frame(exp_sel[2]));
      end
      measure(m);
      checks++;
      if (timing_of(m) !== exp_timing(1024)) begin
         errors++;
         $display("FAIL cont_last_timing: got %h, expected %h", timing_of(m), exp_timing(1024));
      end
      checks++;
      if (frame_of(m) !== exp_frame(2'd1)) begin
         errors++;
         $display("FAIL cont_last_frame: got %h, expected %h", frame_of(m), exp_frame(2'd1));
      end
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         seen = seen | busy | ctr_reset;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL cont_stop: activity=%b, expected 0", seen);
      end
      gate_len_sel = 2'd0;
   endtask

   task automatic test_back_to_back();
      meas_t m;
      logic seen;
      int n;
      ro_mask = 3'b001;
      continuous = 1'b0;
      pulse_start();
      fork
         measure(m);
         begin
            n = 0;
            while (ser_valid !== 1'b1 && n < 2000) begin
               @(negedge clk);
               n++;
            end
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      checks++;
      if (timing_of(m) !== exp_timing(1024)) begin
         errors++;
         $display("FAIL b2b_timing: got %h, expected %h", timing_of(m), exp_timing(1024));
      end
      checks++;
      if (frame_of(m) !== exp_frame(2'd0)) begin
         errors++;
         $display("FAIL b2b_frame: got %h, expected %h", frame_of(m), exp_frame(2'd0));
      end
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         seen = seen | busy | ctr_reset;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_restart: activity=%b, expected 0", seen);
      end
   endtask

   task automatic test_invariants();
      checks++;
      if (excl_viol !== 0) begin
         errors++;
         $display("FAIL strobe_exclusive: %0d overlaps, expected 0", excl_viol);
      end
      checks++;
      if (data_viol !== 0) begin
         errors++;
         $display("FAIL ser_data_quiet: %0d cycles, expected 0", data_viol);
      end
      checks++;
      if (sel_viol !== 0) begin
         errors++;
         $display("FAIL select_stable: %0d changes outside NEXT, expected 0", sel_viol);
      end
   endtask

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      continuous   = 1'b0;
      ro_mask      = 3'b000;
      gate_len_sel = 2'd0;
      cycle_count  = 20'h12345;
      test_reset();
      test_basic();
      test_gate_len();
      test_empty_mask();
      test_reset_mid();
      test_continuous();
      test_back_to_back();
      test_invariants();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
